// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber arithmetic constants for the NTT modular datapath
package kyber_pkg;

   localparam int KYBER_DATA_WIDTH = 12;
   localparam int KYBER_Q          = 3329;
   localparam int KYBER_BARRETT_K  = 2 * KYBER_DATA_WIDTH;
   localparam int KYBER_BARRETT_M  = (1 << KYBER_BARRETT_K) / KYBER_Q;

   // Bits needed to hold the Barrett constant m.
   function automatic int barrett_m_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mod_barrett_reduce.sv
// rtl/mod_barrett_reduce.sv - three-stage Barrett reduction of a 2*DATA_WIDTH product
module mod_barrett_reduce
   import kyber_pkg::*;
#(
   parameter int DATA_WIDTH = KYBER_DATA_WIDTH,
   parameter int MODULUS    = KYBER_Q,
   parameter int BARRETT_K  = KYBER_BARRETT_K,
   parameter int BARRETT_M  = KYBER_BARRETT_M
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable_i,
   input  logic                      valid_i,
   input  logic [2*DATA_WIDTH-1:0]   p_i,
   output logic [DATA_WIDTH-1:0]     result_o,
   output logic                      valid_o
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int MW = barrett_m_width(BARRETT_M);
   localparam int RW = DATA_WIDTH + 2;
   localparam logic [MW-1:0] M_W = MW'(BARRETT_M);
   localparam logic [RW-1:0] Q_R = RW'(MODULUS);

   logic [PW+MW-1:0] pm;
   logic [RW-1:0]    qh_d, qh_q;
   logic [RW-1:0]    p2_d, p2_q;
   logic [RW-1:0]    r_d, r_q;
   logic [DATA_WIDTH-1:0] res_d, res_q;
   logic             v2_q, v3_q, v4_q;

   // True remainder is below 2*MODULUS, so everything after the quotient
   // estimate can be done modulo 2^RW without losing information.
   always_comb begin
      pm    = {{MW{1'b0}}, p_i} * {{PW{1'b0}}, M_W};
      qh_d  = RW'(pm >> BARRETT_K);
      p2_d  = RW'(p_i);
      r_d   = p2_q - (qh_q * Q_R);
      res_d = DATA_WIDTH'((r_q >= Q_R) ? (r_q - Q_R) : r_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qh_q  <= '0;
         p2_q  <= '0;
         r_q   <= '0;
         res_q <= '0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         v4_q  <= 1'b0;
      end else if (enable_i) begin
         qh_q  <= qh_d;
         p2_q  <= p2_d;
         r_q   <= r_d;
         res_q <= res_d;
         v2_q  <= valid_i;
         v3_q  <= v2_q;
         v4_q  <= v3_q;
      end
   end

   assign result_o = res_q;
   assign valid_o  = v4_q;

endmodule

// File: rtl/mod_mult_barrett_pipeline.sv
// rtl/mod_mult_barrett_pipeline.sv - 4-stage (a*b) mod q multiplier; MOD_MULT_RANGE_CHECK_EN adds range_err
module mod_mult_barrett_pipeline
   import kyber_pkg::*;
#(
   parameter int DATA_WIDTH = KYBER_DATA_WIDTH,
   parameter int MODULUS    = KYBER_Q,
   parameter int BARRETT_K  = KYBER_BARRETT_K,
   parameter int BARRETT_M  = KYBER_BARRETT_M
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  valid_out
`ifdef MOD_MULT_RANGE_CHECK_EN
   ,
   output logic                  range_err
`endif
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [PW-1:0] p_d, p_q;
   logic          v1_q;

`ifdef MOD_MULT_RANGE_CHECK_EN
   localparam logic [DATA_WIDTH:0] Q_X = (DATA_WIDTH + 1)'(MODULUS);
   logic       rerr_d;
   logic [3:0] rerr_q;

   // An out-of-range item enters the reducer as p=0 so its result comes out 0.
   always_comb begin
      rerr_d = ({1'b0, a} >= Q_X) || ({1'b0, b} >= Q_X);
      p_d    = rerr_d ? '0 : ({{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rerr_q <= '0;
      end else if (enable) begin
         rerr_q <= {rerr_q[2:0], rerr_d};
      end
   end

   assign range_err = rerr_q[3];
`else
   always_comb begin
      p_d = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q  <= '0;
         v1_q <= 1'b0;
      end else if (enable) begin
         p_q  <= p_d;
         v1_q <= valid_in;
      end
   end

   mod_barrett_reduce #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODULUS    (MODULUS),
      .BARRETT_K  (BARRETT_K),
      .BARRETT_M  (BARRETT_M)
   ) u_reduce (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable),
      .valid_i  (v1_q),
      .p_i      (p_q),
      .result_o (result),
      .valid_o  (valid_out)
   );

endmodule

// File: tb/tb_mod_mult_barrett_pipeline.sv
// tb/tb_mod_mult_barrett_pipeline.sv - randomized self-checking bench for mod_mult_barrett_pipeline
module tb_mod_mult_barrett_pipeline;

   localparam int Q = 3329;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        valid_in = 1'b0;
   logic [11:0] a = '0;
   logic [11:0] b = '0;
   logic [11:0] result;
   logic        valid_out;
`ifdef MOD_MULT_RANGE_CHECK_EN
   logic        range_err;
   bit          exp_rerr;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      int val;
      int age;
      bit rerr;
   } item_t;

   item_t mq[$];
   bit    exp_vo;
   int    exp_res;

   mod_mult_barrett_pipeline dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .valid_in  (valid_in),
      .a         (a),
      .b         (b),
      .result    (result),
      .valid_out (valid_out)
`ifdef MOD_MULT_RANGE_CHECK_EN
      ,
      .range_err (range_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      exp_vo  = 1'b0;
      exp_res = 0;
`ifdef MOD_MULT_RANGE_CHECK_EN
      exp_rerr = 1'b0;
`endif
   endtask

   // Drive one cycle, then advance the reference: an accepted item surfaces
   // after exactly four enabled edges; disabled edges change nothing.
   task automatic step(input bit en, input bit v, input int aa, input int bb);
      item_t it;
      enable   = en;
      valid_in = v;
      a        = aa[11:0];
      b        = bb[11:0];
      @(posedge clk);
      #1;
      if (en) begin
         if (v) begin
            it.val  = (aa * bb) % Q;
            it.rerr = 1'b0;
`ifdef MOD_MULT_RANGE_CHECK_EN
            if (aa >= Q || bb >= Q) begin
               it.val  = 0;
               it.rerr = 1'b1;
            end
`endif
            it.age = 0;
            mq.push_back(it);
         end
         for (int i = 0; i < mq.size(); i++) begin
            it = mq[i];
            it.age++;
            mq[i] = it;
         end
         if (mq.size() > 0 && mq[0].age == 4) begin
            exp_vo  = 1'b1;
            exp_res = mq[0].val;
`ifdef MOD_MULT_RANGE_CHECK_EN
            exp_rerr = mq[0].rerr;
`endif
            void'(mq.pop_front());
         end else begin
            exp_vo = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid_out: got %b expected 0", valid_out);
      end
      checks++;
      if (result !== 12'd0) begin
         errors++;
         $display("FAIL reset_result: got %0d expected 0", result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 1'b0, 0, 0);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got %b expected 0", valid_out);
      end
   endtask

   task automatic test_single();
      int sa[4] = '{17, 3328, 1665, 0};
      int sb[4] = '{17, 3328, 2, 3328};
      int se[4] = '{289, 1, 1, 0};
      int lat;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b1, sa[k], sb[k]);
         lat = 1;
         while (valid_out !== 1'b1 && lat < 20) begin
            step(1'b1, 1'b0, 0, 0);
            lat++;
         end
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("FAIL single_latency[%0d]: got %0d cycles expected 4", k, lat);
         end
         checks++;
         if (result !== se[k][11:0]) begin
            errors++;
            $display("FAIL single_result[%0d]: got %0d expected %0d", k, result, se[k]);
         end
         step(1'b1, 1'b0, 0, 0);
      end
   endtask

   task automatic test_stream();
      bit vo_req;
      int nout = 0;
      for (int k = 0; k < 14; k++) begin
         if (k < 8) step(1'b1, 1'b1, 3328, k + 1);
         else       step(1'b1, 1'b0, 0, 0);
         vo_req = (k >= 3 && k <= 10);
         checks++;
         if (valid_out !== vo_req) begin
            errors++;
            $display("FAIL stream_valid[%0d]: got %b expected %b", k, valid_out, vo_req);
         end
         if (vo_req) begin
            nout++;
            checks++;
            if (result !== 12'(Q - (k - 2))) begin
               errors++;
               $display("FAIL stream_result[%0d]: got %0d expected %0d", k, result, Q - (k - 2));
            end
         end
      end
   endtask

   task automatic test_stall();
      int nout = 0;
      logic [11:0] hold_res;
      logic        hold_vo;
      step(1'b1, 1'b1, 1234, 2345);
      step(1'b1, 1'b1, 3000, 3001);
      hold_res = result;
      hold_vo  = valid_out;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 77, 88);
         checks++;
         if (valid_out !== hold_vo || result !== hold_res) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got vo=%b res=%0d expected vo=%b res=%0d",
                     k, valid_out, result, hold_vo, hold_res);
         end
      end
      step(1'b1, 1'b1, 999, 1001);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b0, 0, 0);
         checks++;
         if (valid_out !== exp_vo) begin
            errors++;
            $display("FAIL stall_valid[%0d]: got %b expected %b", k, valid_out, exp_vo);
         end
         if (exp_vo) begin
            nout++;
            checks++;
            if (result !== exp_res[11:0]) begin
               errors++;
               $display("FAIL stall_result[%0d]: got %0d expected %0d", k, result, exp_res);
            end
         end
      end
      checks++;
      if (nout !== 3) begin
         errors++;
         $display("FAIL stall_count: got %0d outputs expected 3", nout);
      end
   endtask

   task automatic test_reset_midstream();
      int lat;
      step(1'b1, 1'b1, 100, 200);
      step(1'b1, 1'b1, 300, 400);
      step(1'b1, 1'b1, 500, 600);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || result !== 12'd0) begin
         errors++;
         $display("FAIL midstream_reset: got vo=%b res=%0d expected vo=0 res=0", valid_out, result);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 0, 0);
         checks++;
         if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset[%0d]: got %b expected 0", k, valid_out);
         end
      end
      step(1'b1, 1'b1, 2000, 3000);
      lat = 1;
      while (valid_out !== 1'b1 && lat < 20) begin
         step(1'b1, 1'b0, 0, 0);
         lat++;
      end
      checks++;
      if (lat !== 4 || result !== 12'((2000 * 3000) % Q)) begin
         errors++;
         $display("FAIL first_after_reset: got lat=%0d res=%0d expected lat=4 res=%0d",
                  lat, result, (2000 * 3000) % Q);
      end
      step(1'b1, 1'b0, 0, 0);
   endtask

   task automatic test_random();
      int accepted = 0;
      int cycles = 0;
      bit en, v;
      while (accepted < 10000 && cycles < 40000) begin
         en = ($urandom_range(0, 99) < 85);
         v  = ($urandom_range(0, 99) < 75);
         if (en && v) accepted++;
         step(en, v, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
         cycles++;
         checks++;
         if (valid_out !== exp_vo) begin
            errors++;
            $display("FAIL random_valid[%0d]: got %b expected %b", cycles, valid_out, exp_vo);
         end
         if (exp_vo) begin
            checks++;
            if (result !== exp_res[11:0]) begin
               errors++;
               $display("FAIL random_result[%0d]: got %0d expected %0d", cycles, result, exp_res);
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 0, 0);
         checks++;
         if (valid_out !== exp_vo || (exp_vo && result !== exp_res[11:0])) begin
            errors++;
            $display("FAIL random_drain[%0d]: got vo=%b res=%0d expected vo=%b res=%0d",
                     k, valid_out, result, exp_vo, exp_res);
         end
      end
      checks++;
      if (accepted !== 10000) begin
         errors++;
         $display("FAIL random_budget: got %0d accepted expected 10000", accepted);
      end
   endtask

`ifdef MOD_MULT_RANGE_CHECK_EN
   task automatic test_range();
      for (int k = 0; k < 7; k++) begin
         if (k == 0)      step(1'b1, 1'b1, 3329, 5);
         else if (k == 1) step(1'b1, 1'b1, 3328, 5);
         else             step(1'b1, 1'b0, 0, 0);
         if (k == 3) begin
            checks++;
            if (valid_out !== 1'b1 || range_err !== 1'b1 || result !== 12'd0) begin
               errors++;
               $display("FAIL range_bad: got vo=%b err=%b res=%0d expected vo=1 err=1 res=0",
                        valid_out, range_err, result);
            end
         end
         if (k == 4) begin
            checks++;
            if (valid_out !== 1'b1 || range_err !== 1'b0 || result !== 12'd3324) begin
               errors++;
               $display("FAIL range_good: got vo=%b err=%b res=%0d expected vo=1 err=0 res=3324",
                        valid_out, range_err, result);
            end
         end
         if (exp_vo) begin
            checks++;
            if (range_err !== exp_rerr) begin
               errors++;
               $display("FAIL range_model[%0d]: got %b expected %b", k, range_err, exp_rerr);
            end
         end
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_stream();
      test_stall();
      test_reset_midstream();
`ifdef MOD_MULT_RANGE_CHECK_EN
      test_range();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
